// File: rtl/mips_defs.sv
// Shared MIPS definitions: MDU operation encodings and default multi-cycle latencies.
package mips_defs;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  function automatic logic is_md_arith(md_op_e op);
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// E-stage MDU request/response bundle between the pipeline and the MDU controller.
interface mdu_ctrl_if;
  logic [2:0]  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        md_use_d;
  logic        busy;
  logic        start;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output md_op, md_a, md_b, md_use_d,
    input  busy, start, stall, hi, lo
  );

  modport slave (
    input  md_op, md_a, md_b, md_use_d,
    output busy, start, stall, hi, lo
  );
endinterface

// File: rtl/mdu_calc.sv
// Combinational multiply/divide arithmetic; a single unsigned divider serves both div and divu.
module mdu_calc
  import mips_defs::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] prod;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        is_div;
  logic        neg_q;
  logic        neg_r;

  always_comb begin
    mul_a = {32'h0, a};
    mul_b = {32'h0, b};
    if (op == MD_MULT) begin
      mul_a = {{32{a[31]}}, a};
      mul_b = {{32{b[31]}}, b};
    end
    // Low 64 bits of the product of sign-extended operands equal the signed product.
    prod = mul_a * mul_b;

    is_div   = (op == MD_DIV) || (op == MD_DIVU);
    div_zero = is_div && (b == '0);

    // Signed divide via magnitudes; 0x80000000 / -1 wraps back to 0x80000000 naturally.
    neg_q = (op == MD_DIV) && (a[31] ^ b[31]);
    neg_r = (op == MD_DIV) && a[31];
    dvd   = ((op == MD_DIV) && a[31]) ? -a : a;
    dvs   = ((op == MD_DIV) && b[31]) ? -b : b;
    quo   = (dvs == '0) ? '0 : dvd / dvs;
    rem   = (dvs == '0) ? '0 : dvd % dvs;

    res_hi = prod[63:32];
    res_lo = prod[31:0];
    if (is_div) begin
      res_lo = neg_q ? -quo : quo;
      res_hi = neg_r ? -rem : rem;
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: owns HI/LO, models mult/div latency with a busy counter and raises the decode stall.
module mdu_ctrl
  import mips_defs::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  mdu_ctrl_if.slave  bus
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t MULT_N = cnt_t'(MULT_CYCLES);
  localparam cnt_t DIV_N  = cnt_t'(DIV_CYCLES);
  localparam cnt_t ONE    = cnt_t'(1);

  md_op_e      op;
  cnt_t        count, count_nxt;
  logic [31:0] hi, hi_nxt;
  logic [31:0] lo, lo_nxt;
  logic [31:0] res_hi, res_hi_nxt;
  logic [31:0] res_lo, res_lo_nxt;
  logic        res_wr, res_wr_nxt;
  logic [31:0] calc_hi;
  logic [31:0] calc_lo;
  logic        calc_div_zero;
  logic        busy;
  logic        start;

  assign op = md_op_e'(bus.md_op);

  mdu_calc u_calc (
    .op       (op),
    .a        (bus.md_a),
    .b        (bus.md_b),
    .res_hi   (calc_hi),
    .res_lo   (calc_lo),
    .div_zero (calc_div_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      hi     <= '0;
      lo     <= '0;
      res_hi <= '0;
      res_lo <= '0;
      res_wr <= 1'b0;
    end else begin
      count  <= count_nxt;
      hi     <= hi_nxt;
      lo     <= lo_nxt;
      res_hi <= res_hi_nxt;
      res_lo <= res_lo_nxt;
      res_wr <= res_wr_nxt;
    end
  end

  always_comb begin
    count_nxt  = count;
    hi_nxt     = hi;
    lo_nxt     = lo;
    res_hi_nxt = res_hi;
    res_lo_nxt = res_lo;
    res_wr_nxt = res_wr;
    if (start) begin
      count_nxt  = (op == MD_MULT || op == MD_MULTU) ? MULT_N : DIV_N;
      res_hi_nxt = calc_hi;
      res_lo_nxt = calc_lo;
      res_wr_nxt = !calc_div_zero;
    end else if (busy) begin
      count_nxt = count - ONE;
      // Commit on the final busy edge; a zero-divisor result never reaches HI/LO.
      if (count == ONE && res_wr) begin
        hi_nxt = res_hi;
        lo_nxt = res_lo;
      end
    end else if (op == MD_MTHI) begin
      hi_nxt = bus.md_a;
    end else if (op == MD_MTLO) begin
      lo_nxt = bus.md_a;
    end
  end

  always_comb begin
    busy      = (count != '0);
    start     = is_md_arith(op) && !busy;
    bus.busy  = busy;
    bus.start = start;
    bus.stall = bus.md_use_d && (start || busy);
    bus.hi    = hi;
    bus.lo    = lo;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: a driver with a behavioural model pushes expected commits, a monitor checks them.
module tb_mdu_ctrl;
  import mips_defs::*;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned n;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  mdu_ctrl_if bus ();

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        p_wr;
  int unsigned m_left;
  string       cur_tag = "init";

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference arithmetic straight from the ISA definition, using 64-bit host integers.
  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sbv, q, r, p;
    longint unsigned ua, ub, uq, ur;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    case (op)
      3'd1: begin p = sa * sbv; return 64'(p); end
      3'd2: return ua * ub;
      3'd3: begin q = sa / sbv; r = sa % sbv; return {r[31:0], q[31:0]}; end
      3'd4: begin uq = ua / ub; ur = ua % ub; return {ur[31:0], uq[31:0]}; end
      default: return '0;
    endcase
  endfunction

  task automatic cyc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic use_d, input logic rst = 1'b0);
    logic        exp_start;
    logic [63:0] r;
    exp_t        e;
    reset        = rst;
    bus.md_op    = op;
    bus.md_a     = a;
    bus.md_b     = b;
    bus.md_use_d = use_d;
    exp_start    = (op >= 3'd1 && op <= 3'd4) && (m_left == 0);
    @(negedge clk);
    check({cur_tag, "_busy"},  bus.busy,  m_left != 0);
    check({cur_tag, "_start"}, bus.start, exp_start);
    check({cur_tag, "_stall"}, bus.stall, use_d && (exp_start || m_left != 0));
    check({cur_tag, "_hi"},    bus.hi,    m_hi);
    check({cur_tag, "_lo"},    bus.lo,    m_lo);
    @(posedge clk);
    if (rst) begin
      m_hi = '0; m_lo = '0; m_left = 0; p_wr = 1'b0;
      sb.delete();
    end else if (m_left != 0) begin
      m_left--;
      if (m_left == 0 && p_wr) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (exp_start) begin
      e.n   = (op <= 3'd2) ? MC : DC;
      e.tag = cur_tag;
      m_left = e.n;
      if (op >= 3'd3 && b == '0) begin
        p_wr = 1'b0;
        e.hi = m_hi;
        e.lo = m_lo;
      end else begin
        r    = ref_md(op, a, b);
        p_hi = r[63:32];
        p_lo = r[31:0];
        p_wr = 1'b1;
        e.hi = p_hi;
        e.lo = p_lo;
      end
      sb.push_back(e);
    end else if (op == 3'd5) begin
      m_hi = a;
    end else if (op == 3'd6) begin
      m_lo = a;
    end
    #1;
  endtask

  task automatic idle(input int unsigned n, input logic use_d = 1'b1);
    repeat (n) cyc(MD_NONE, $urandom, $urandom, use_d);
  endtask

  // Monitor: each busy->idle transition must match the oldest outstanding op.
  initial begin : monitor
    logic        prev;
    int unsigned run;
    exp_t        e;
    prev = 1'b0;
    run  = 0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        prev = 1'b0;
        run  = 0;
      end else begin
        if (bus.busy === 1'b1) begin
          run++;
        end else if (prev) begin
          check("commit_pending", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check({e.tag, "_commit_hi"}, bus.hi, e.hi);
            check({e.tag, "_commit_lo"}, bus.lo, e.lo);
            check({e.tag, "_busy_len"}, run, e.n);
          end
          run = 0;
        end
        prev = (bus.busy === 1'b1);
      end
    end
  end

  initial begin : driver
    logic [2:0] rop;
    logic [31:0] ra, rb;
    reset = 1'b1;
    bus.md_op = MD_NONE; bus.md_a = '0; bus.md_b = '0; bus.md_use_d = 1'b0;
    m_hi = '0; m_lo = '0; m_left = 0; p_wr = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    cur_tag = "reset";
    idle(2, 1'b0);

    cur_tag = "mult";
    cyc(MD_MULT, 32'd3, 32'hFFFF_FFFC, 1'b1);
    idle(MC);
    check("mult_hi_const", bus.hi, 32'hFFFF_FFFF);
    check("mult_lo_const", bus.lo, 32'hFFFF_FFF4);

    cur_tag = "multu";
    cyc(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1);
    idle(MC);
    check("multu_hi_const", bus.hi, 32'h0000_0001);
    check("multu_lo_const", bus.lo, 32'hFFFF_FFFE);

    cur_tag = "div";
    cyc(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    idle(DC, 1'b0);
    check("div_hi_const", bus.hi, 32'hFFFF_FFFF);
    check("div_lo_const", bus.lo, 32'hFFFF_FFFD);

    cur_tag = "divu0";
    cyc(MD_MTHI, 32'h11, '0, 1'b1);
    cyc(MD_MTLO, 32'h22, '0, 1'b1);
    cyc(MD_DIVU, 32'h64, 32'h0, 1'b1);
    idle(DC);
    check("divu0_hi_const", bus.hi, 32'h11);
    check("divu0_lo_const", bus.lo, 32'h22);

    cur_tag = "divovf";
    cyc(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    idle(DC);
    check("divovf_hi_const", bus.hi, 32'h0);
    check("divovf_lo_const", bus.lo, 32'h8000_0000);

    cur_tag = "ignored";
    cyc(MD_MULT, 32'h1234, 32'h10, 1'b1);
    cyc(MD_NONE, '0, '0, 1'b1);
    cyc(MD_MTHI, 32'hABCD, '0, 1'b1);
    cyc(MD_MULT, 32'h7777, 32'h9999, 1'b1);
    idle(MC - 3);
    check("ignored_hi_const", bus.hi, 32'h0);
    check("ignored_lo_const", bus.lo, 32'h0001_2340);
    idle(1);

    cur_tag = "rstdiv";
    cyc(MD_DIV, 32'd100, 32'd7, 1'b1);
    idle(3);
    cyc(MD_NONE, '0, '0, 1'b1, 1'b1);
    check("rstdiv_busy_const", bus.busy, 1'b0);
    check("rstdiv_hi_const", bus.hi, 32'h0);
    check("rstdiv_lo_const", bus.lo, 32'h0);
    idle(DC + 2);

    cur_tag = "rand";
    for (int i = 0; i < 400; i++) begin
      rop = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : MD_NONE;
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 3) == 0) ra = {{28{ra[31]}}, ra[3:0]};
      cyc(rop, ra, rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 149) == 0));
    end
    idle(DC + 2);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
